// File: rtl/mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_loader
// Description : Host-side initiator for the CPU external memory ports.
//               Decodes a byte-wide host command stream (IMEM load, DMEM
//               load, DMEM readback, START, STOP). It drives the instruction
//               and data memory external ports and the CPU enable.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, arst_n              clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   host command byte stream (in)
//   m_valid/m_ready/m_data   readback byte stream (out)
//   cpu_enable               drives cpu.enable
//   addr_ext, wen_ext, ren_ext, wdata_ext, rdata_ext
//                            instruction-memory external port (32-bit words)
//   addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, rdata_ext_2
//                            data-memory external port (64-bit words)
//   busy                     loader is not idle
//   err                      sticky unknown-command flag
// Configuration macro:
//   MEM_LOADER_READBACK_EN   enables the 0x03 DMEM readback command; when
//                            undefined, 0x03 is an unknown command and
//                            m_valid/m_data/ren_ext_2 are tied low.
// ============================================================================
module mem_loader (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] HDR_IMEM  = 8'h01;
    localparam logic [7:0] HDR_DMEM  = 8'h02;
    localparam logic [7:0] HDR_DRD   = 8'h03;
    localparam logic [7:0] HDR_START = 8'h04;
    localparam logic [7:0] HDR_STOP  = 8'h05;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR0   = 4'd1,
        ADDR1   = 4'd2,
        LEN0    = 4'd3,
        LEN1    = 4'd4,
        DATA    = 4'd5,
        WRITE   = 4'd6
`ifdef MEM_LOADER_READBACK_EN
        ,
        RD_REQ  = 4'd7,
        RD_WAIT = 4'd8,
        RD_SEND = 4'd9
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        load_hdr;
    logic        last_byte;
    logic [15:0] idx;
    logic [15:0] idx_inc;
    logic [15:0] cnt;        // words remaining in the current frame
    logic [2:0]  byte_cnt;   // payload bytes collected for the current word
    logic        is_dmem;
    logic [55:0] wbuf;       // payload bytes enter at the top, oldest at bottom

`ifdef MEM_LOADER_READBACK_EN
    logic        is_read;
    logic [2:0]  rd_cnt;
    logic [55:0] rbuf;       // bytes 1..7 of the fetched word, next byte lowest
    logic        unused_inputs;
    assign unused_inputs = ^rdata_ext;
`else
    logic        unused_inputs;
    assign unused_inputs = ^{rdata_ext, rdata_ext_2, m_ready};
    assign m_valid   = 1'b0;
    assign m_data    = 8'h00;
    assign ren_ext_2 = 1'b0;
`endif

    assign ren_ext = 1'b0;

    assign s_ready = (state == IDLE) || (state == ADDR0) || (state == ADDR1) ||
                     (state == LEN0) || (state == LEN1)  || (state == DATA);
    assign busy    = (state != IDLE);
    assign accept  = s_valid && s_ready;
    assign idx_inc = idx + 16'd1;

`ifdef MEM_LOADER_READBACK_EN
    assign load_hdr = (s_data == HDR_IMEM) || (s_data == HDR_DMEM) ||
                      (s_data == HDR_DRD);
`else
    assign load_hdr = (s_data == HDR_IMEM) || (s_data == HDR_DMEM);
`endif

    assign last_byte = is_dmem ? (byte_cnt == 3'd7) : (byte_cnt == 3'd3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept && load_hdr) state_nxt = ADDR0;
            ADDR0: if (accept) state_nxt = ADDR1;
            ADDR1: if (accept) state_nxt = LEN0;
            LEN0:  if (accept) state_nxt = LEN1;
            LEN1: begin
                if (accept) begin
                    // a zero-length frame ends here without touching memory
                    if ({s_data, cnt[7:0]} == 16'd0) begin
                        state_nxt = IDLE;
`ifdef MEM_LOADER_READBACK_EN
                    end else if (is_read) begin
                        state_nxt = RD_REQ;
`endif
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA:  if (accept && last_byte) state_nxt = WRITE;
            WRITE: state_nxt = (cnt == 16'd1) ? IDLE : DATA;
`ifdef MEM_LOADER_READBACK_EN
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = RD_SEND;
            RD_SEND: begin
                if (m_ready && (rd_cnt == 3'd7)) begin
                    state_nxt = (cnt == 16'd1) ? IDLE : RD_REQ;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cpu_enable  <= 1'b0;
            err         <= 1'b0;
            wen_ext     <= 1'b0;
            wen_ext_2   <= 1'b0;
            addr_ext    <= 64'd0;
            addr_ext_2  <= 64'd0;
            wdata_ext   <= 32'd0;
            wdata_ext_2 <= 64'd0;
            idx         <= 16'd0;
            cnt         <= 16'd0;
            byte_cnt    <= 3'd0;
            is_dmem     <= 1'b0;
            wbuf        <= 56'd0;
`ifdef MEM_LOADER_READBACK_EN
            is_read     <= 1'b0;
            rd_cnt      <= 3'd0;
            rbuf        <= 56'd0;
            ren_ext_2   <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= 8'h00;
`endif
        end else begin
            // strobes are single-cycle unless re-asserted below
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
`ifdef MEM_LOADER_READBACK_EN
            ren_ext_2 <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (load_hdr) begin
                            // halt the CPU before any memory access
                            cpu_enable <= 1'b0;
                            err        <= 1'b0;
                            is_dmem    <= (s_data != HDR_IMEM);
`ifdef MEM_LOADER_READBACK_EN
                            is_read    <= (s_data == HDR_DRD);
`endif
                        end else if (s_data == HDR_START) begin
                            cpu_enable <= 1'b1;
                            err        <= 1'b0;
                        end else if (s_data == HDR_STOP) begin
                            cpu_enable <= 1'b0;
                            err        <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ADDR0: if (accept) idx[7:0]  <= s_data;
                ADDR1: if (accept) idx[15:8] <= s_data;
                LEN0:  if (accept) cnt[7:0]  <= s_data;
                LEN1: begin
                    if (accept) begin
                        cnt[15:8] <= s_data;
                        byte_cnt  <= 3'd0;
`ifdef MEM_LOADER_READBACK_EN
                        if (state_nxt == RD_REQ) begin
                            ren_ext_2  <= 1'b1;
                            addr_ext_2 <= {45'b0, idx, 3'b000};
                        end
`endif
                    end
                end
                DATA: begin
                    if (accept) begin
                        wbuf     <= {s_data, wbuf[55:8]};
                        byte_cnt <= byte_cnt + 3'd1;
                        if (last_byte) begin
                            // address and data are presented together with
                            // the strobe for the single WRITE cycle
                            if (is_dmem) begin
                                wen_ext_2   <= 1'b1;
                                addr_ext_2  <= {45'b0, idx, 3'b000};
                                wdata_ext_2 <= {s_data, wbuf};
                            end else begin
                                wen_ext   <= 1'b1;
                                addr_ext  <= {46'b0, idx, 2'b00};
                                wdata_ext <= {s_data, wbuf[55:32]};
                            end
                        end
                    end
                end
                WRITE: begin
                    idx      <= idx_inc;
                    cnt      <= cnt - 16'd1;
                    byte_cnt <= 3'd0;
                end
`ifdef MEM_LOADER_READBACK_EN
                RD_WAIT: begin
                    // memory returns the word one cycle after the request
                    m_data  <= rdata_ext_2[7:0];
                    rbuf    <= rdata_ext_2[63:8];
                    m_valid <= 1'b1;
                    rd_cnt  <= 3'd0;
                end
                RD_SEND: begin
                    if (m_ready) begin
                        rd_cnt <= rd_cnt + 3'd1;
                        m_data <= rbuf[7:0];
                        rbuf   <= {8'h00, rbuf[55:8]};
                        if (rd_cnt == 3'd7) begin
                            m_valid <= 1'b0;
                            if (cnt != 16'd1) begin
                                idx        <= idx_inc;
                                cnt        <= cnt - 16'd1;
                                ren_ext_2  <= 1'b1;
                                addr_ext_2 <= {45'b0, idx_inc, 3'b000};
                            end
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_loader
// Description : Scoreboard bench for mem_loader. Stimulus tasks push the
//               expected memory writes and readback bytes into queues; a
//               negedge monitor pops and compares them as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

`ifdef MEM_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk;
    logic        arst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;
    logic        busy;
    logic        err;

    mem_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata_ext = 32'd0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    longint      cyc   = 0;
    wr_t         exp_imem[$];
    wr_t         exp_dmem[$];
    logic [7:0]  exp_rd[$];
    longint      imem_pulse[$];
    longint      dmem_pulse[$];
    logic [63:0] ref_dmem[int];   // expected data-memory contents by word index
    logic [63:0] mem_dmem[int];   // data memory as written by the DUT
    int          ready_mode = 0;  // 0: always ready, 1: toggle, 2: random
    bit          gap_en = 1'b0;
    logic        exp_en = 1'b0;
    logic        exp_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected event/timeout expected none", name);
    endtask

    // Data memory: synchronous read, data valid the cycle after ren_ext_2.
    always @(posedge clk) begin
        if (wen_ext_2) mem_dmem[int'(addr_ext_2[18:3])] = wdata_ext_2;
        if (ren_ext_2)
            rdata_ext_2 <= mem_dmem.exists(int'(addr_ext_2[18:3])) ?
                           mem_dmem[int'(addr_ext_2[18:3])] : 64'd0;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (arst_n) begin
            cyc++;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (wen_ext) begin
                imem_pulse.push_back(cyc);
                if (exp_imem.size() == 0) unexpected("imem_wen");
                else begin
                    e = exp_imem.pop_front();
                    chk("imem_addr", addr_ext, e.addr);
                    chk("imem_data", 64'(wdata_ext), e.data);
                end
            end
            if (wen_ext_2) begin
                dmem_pulse.push_back(cyc);
                if (exp_dmem.size() == 0) unexpected("dmem_wen");
                else begin
                    e = exp_dmem.pop_front();
                    chk("dmem_addr", addr_ext_2, e.addr);
                    chk("dmem_data", wdata_ext_2, e.data);
                end
            end
            if (ren_ext) unexpected("ren_ext");
            if (m_valid) begin
                if (exp_rd.size() == 0) unexpected("m_valid");
                else begin
                    chk("m_data", 64'(m_data), 64'(exp_rd[0]));
                    if (m_ready) void'(exp_rd.pop_front());
                end
            end
        end else begin
            m_ready = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (gap_en && ($urandom_range(0, 3) == 0))
            repeat ($urandom_range(1, 3)) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            unexpected("s_ready_timeout");
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] h);
        send_byte(h);
        if (h == 8'h01 || h == 8'h02 || (RB && h == 8'h03)) begin
            exp_en = 1'b0; exp_err = 1'b0;
        end else if (h == 8'h04) begin
            exp_en = 1'b1; exp_err = 1'b0;
        end else if (h == 8'h05) begin
            exp_en = 1'b0; exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        chk("hdr_cpu_enable", 64'(cpu_enable), 64'(exp_en));
        chk("hdr_err", 64'(err), 64'(exp_err));
    endtask

    task automatic wr_frame(input bit dmem, input logic [15:0] idx, input logic [63:0] words[$]);
        int          nb;
        logic [15:0] len;
        nb  = dmem ? 8 : 4;
        len = 16'(words.size());
        for (int w = 0; w < words.size(); w++) begin
            logic [15:0] wi;
            wr_t         e;
            wi = idx + 16'(w);
            if (dmem) begin
                e.addr = 64'(wi) * 8;
                e.data = words[w];
                exp_dmem.push_back(e);
                ref_dmem[int'(wi)] = words[w];
            end else begin
                e.addr = 64'(wi) * 4;
                e.data = words[w] & 64'hFFFF_FFFF;
                exp_imem.push_back(e);
            end
        end
        send_hdr(dmem ? 8'h02 : 8'h01);
        send_byte(idx[7:0]);
        send_byte(idx[15:8]);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int w = 0; w < words.size(); w++)
            for (int b = 0; b < nb; b++)
                send_byte(words[w][8*b +: 8]);
    endtask

    task automatic rd_frame(input logic [15:0] idx, input logic [15:0] len);
        for (int w = 0; w < int'(len); w++) begin
            logic [15:0] wi;
            logic [63:0] d;
            wi = idx + 16'(w);
            d  = ref_dmem.exists(int'(wi)) ? ref_dmem[int'(wi)] : 64'd0;
            for (int b = 0; b < 8; b++) exp_rd.push_back(d[8*b +: 8]);
        end
        send_hdr(8'h03);
        send_byte(idx[7:0]);
        send_byte(idx[15:8]);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_imem.size() != 0 || exp_dmem.size() != 0 ||
                exp_rd.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            unexpected({tag, "_idle_timeout"});
            exp_imem.delete(); exp_dmem.delete(); exp_rd.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cpu_enable"}, 64'(cpu_enable), 64'(exp_en));
        chk({tag, "_err"},        64'(err),        64'(exp_err));
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_s_ready"},    64'(s_ready),    64'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cpu_enable"},  64'(cpu_enable), 64'd0);
        chk({tag, "_wen_ext"},     64'(wen_ext),    64'd0);
        chk({tag, "_wen_ext_2"},   64'(wen_ext_2),  64'd0);
        chk({tag, "_ren_ext"},     64'(ren_ext),    64'd0);
        chk({tag, "_ren_ext_2"},   64'(ren_ext_2),  64'd0);
        chk({tag, "_addr_ext"},    addr_ext,        64'd0);
        chk({tag, "_addr_ext_2"},  addr_ext_2,      64'd0);
        chk({tag, "_wdata_ext"},   64'(wdata_ext),  64'd0);
        chk({tag, "_wdata_ext_2"}, wdata_ext_2,     64'd0);
        chk({tag, "_m_valid"},     64'(m_valid),    64'd0);
        chk({tag, "_m_data"},      64'(m_data),     64'd0);
        chk({tag, "_err"},         64'(err),        64'd0);
        chk({tag, "_busy"},        64'(busy),       64'd0);
        chk({tag, "_s_ready"},     64'(s_ready),    64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish within 90000 cycles");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        logic [63:0] words[$];
        arst_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("reset0");
        arst_n = 1'b1;
        @(negedge clk);

        // IMEM load, back-to-back bytes: 5 cycles per word
        words.delete();
        words.push_back(64'h0010_0513);
        words.push_back(64'h0020_0593);
        imem_pulse.delete();
        wr_frame(1'b0, 16'h0000, words);
        wait_idle("imem");
        chk_state("imem");
        if (imem_pulse.size() == 2) chk("imem_spacing", 64'(imem_pulse[1] - imem_pulse[0]), 64'd5);
        else chk("imem_pulses", 64'(imem_pulse.size()), 64'd2);

        // DMEM load at word 5 -> byte address 0x28
        words.delete();
        words.push_back(64'h8877_6655_4433_2211);
        wr_frame(1'b1, 16'h0005, words);
        wait_idle("dmem");
        chk_state("dmem");

        // DMEM two-word load: 9 cycles per word
        words.delete();
        words.push_back({$urandom, $urandom});
        words.push_back({$urandom, $urandom});
        dmem_pulse.delete();
        wr_frame(1'b1, 16'h0020, words);
        wait_idle("dmem2");
        if (dmem_pulse.size() == 2) chk("dmem_spacing", 64'(dmem_pulse[1] - dmem_pulse[0]), 64'd9);
        else chk("dmem_pulses", 64'(dmem_pulse.size()), 64'd2);

`ifdef MEM_LOADER_READBACK_EN
        ready_mode = 0;
        rd_frame(16'h0005, 16'd1);
        wait_idle("rd_full");
        chk_state("rd_full");
        ready_mode = 1;
        rd_frame(16'h0005, 16'd1);
        wait_idle("rd_toggle");
        ready_mode = 2;
        rd_frame(16'h0020, 16'd2);
        wait_idle("rd_random");
        chk_state("rd_random");
        ready_mode = 0;
`else
        send_hdr(8'h03);
        wait_idle("rd_unknown");
        chk_state("rd_unknown");
`endif

        // START, STOP, then a load header clears enable on its own edge
        send_hdr(8'h04);
        send_hdr(8'h05);
        send_hdr(8'h04);
        words.delete();
        words.push_back(64'(32'hCAFE_0013));
        wr_frame(1'b0, 16'h0010, words);
        wait_idle("start_load");
        chk_state("start_load");

        // Unknown header, then zero-length frame
        send_hdr(8'h7F);
        wait_idle("unknown");
        chk_state("unknown");
        words.delete();
        wr_frame(1'b1, 16'h0000, words);
        chk("zero_len_busy", 64'(busy), 64'd0);
        wait_idle("zero_len");
        chk_state("zero_len");

        // Index wrap 0xFFFF -> 0x0000
        words.delete();
        words.push_back(64'($urandom));
        words.push_back(64'($urandom));
        wr_frame(1'b0, 16'hFFFF, words);
        wait_idle("wrap");
        words.delete();
        words.push_back(64'($urandom));
        wr_frame(1'b0, 16'h0007, words);
        wait_idle("prereset");

        // Reset in the middle of a payload word
        send_hdr(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        arst_n = 1'b0;
        #1;
        chk_reset("midreset");
        exp_en = 1'b0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_reset("postreset");
        words.delete();
        words.push_back(64'($urandom));
        wr_frame(1'b0, 16'h0100, words);
        wait_idle("after_reset");
        chk_state("after_reset");

        // Randomized frames
        gap_en = 1'b1;
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            int          t;
            logic [15:0] idx;
            int          len;
            logic [7:0]  h;
            t   = $urandom_range(0, 5);
            idx = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 7));
            len = $urandom_range(0, 3);
            case (t)
                0, 1: begin
                    words.delete();
                    for (int k = 0; k < len; k++) words.push_back({$urandom, $urandom});
                    wr_frame(t == 1, idx, words);
                end
                2: begin
`ifdef MEM_LOADER_READBACK_EN
                    rd_frame(idx, 16'(len));
`else
                    send_hdr(8'h03);
`endif
                end
                3: send_hdr(8'h04);
                4: send_hdr(8'h05);
                default: begin
                    do h = 8'($urandom_range(0, 255));
                    while (h inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
                    send_hdr(h);
                end
            endcase
            wait_idle("random");
            chk_state("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
